// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register family: the mode
// encoding and small helpers that classify modes for the shift counter.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_LOAD   = 3'b001,
        MODE_SHL    = 3'b010,
        MODE_SHR    = 3'b011,
        MODE_ROL    = 3'b100,
        MODE_ROR    = 3'b101,
        MODE_CLEAR  = 3'b110,
        MODE_PRESET = 3'b111
    } shift_mode_e;

    // Modes that move data by one position and therefore advance the counter.
    function automatic logic mode_is_shift(input shift_mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

    // Modes that put a fresh word into the register and re-arm the counter.
    function automatic logic mode_is_reload(input shift_mode_e m);
        return (m == MODE_LOAD) || (m == MODE_CLEAR) || (m == MODE_PRESET);
    endfunction

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating up-counter with a registered at-max flag and a single-cycle
// pulse on the cycle the count first reaches MAX. Clear wins over increment.
module sat_counter #(
    parameter int MAX = 8,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max,
    output logic         hit_pulse
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_max_q, at_max_d;
    logic         hit_q, hit_d;

    // Next count, saturation flag and first-arrival pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
        at_max_d = (cnt_d == MAX_V);
        // Only the step from MAX-1 to MAX fires; saturated shifts keep cnt_d == cnt_q.
        hit_d    = (cnt_d == MAX_V) && (cnt_q != MAX_V);
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            at_max_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_max_q <= at_max_d;
            hit_q    <= hit_d;
        end
    end

    assign cnt       = cnt_q;
    assign at_max    = at_max_q;
    assign hit_pulse = hit_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, load, logical shift and rotate in
// both directions, clear and preset, with a shift counter and drained/done
// flags so the block can serialise or deserialise a word.
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained,
    output logic             done
);

    shift_mode_e      mode_e;
    logic [WIDTH-1:0] q_q, q_d;
    logic             cnt_clr;
    logic             cnt_inc;

    assign mode_e = shift_mode_e'(mode);

    // Mode-decoded next value of the data register.
    always_comb begin
        q_d = q_q;
        case (mode_e)
            MODE_HOLD:   q_d = q_q;
            MODE_LOAD:   q_d = d;
            MODE_SHL:    q_d = {q_q[WIDTH-2:0], sin_r};
            MODE_SHR:    q_d = {sin_l, q_q[WIDTH-1:1]};
            MODE_ROL:    q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR:    q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_CLEAR:  q_d = '0;
            MODE_PRESET: q_d = RESET_VAL;
            // An unknown mode must poison the register rather than hold quietly.
            default:     q_d = {WIDTH{1'bx}};
        endcase
    end

    // Data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Counter control derived from the mode.
    always_comb begin
        cnt_clr = mode_is_reload(mode_e);
        cnt_inc = mode_is_shift(mode_e);
    end

    sat_counter #(
        .MAX (WIDTH),
        .W   (CNT_W)
    ) u_sat_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .cnt       (shift_cnt),
        .at_max    (drained),
        .hit_pulse (done)
    );

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];

endmodule
